mem_lsu: RTL and testbench

//  MEM-stage load/store unit between exe_mem and mem_wb. Non-memory ops pass

---
 rtl/mem_lsu.sv | 165 ++++++++++++++++
 tb/tb_mem_lsu.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: ALU results pass straight through, loads/stores
// run one req/ack bus transaction while the pipeline is stalled.
module mem_lsu #(
    parameter int TIMEOUT  = 16,
    parameter int TO_WIDTH = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  reg_waddr_i,
    input  logic        reg_we_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [4:0]  reg_waddr_o,
    output logic        reg_we_o,
    output logic [31:0] reg_wdata_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t              state;
    logic [TO_WIDTH-1:0] cnt;
    logic                abort_q;
    logic [31:0]         load_q;
    logic                req_q;
    logic                we_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;

    logic                access;
    logic [1:0]          lane;
    logic                is_byte;
    logic                is_half;
    logic                misaligned;
    logic [3:0]          be_n;
    logic [31:0]         wdata_n;
    logic [31:0]         shifted;
    logic [15:0]         half_sel;
    logic [31:0]         load_n;
    logic [TO_WIDTH-1:0] cnt_inc;
    logic                timed_out;

    assign access     = mem_re_i | mem_we_i;
    assign lane       = mem_addr_i[1:0];
    assign is_byte    = (mem_size_i[1:0] == 2'b00);
    assign is_half    = (mem_size_i[1:0] == 2'b01);
    assign misaligned = (is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00));

    assign shifted    = bus_rdata_i >> {lane, 3'b000};
    assign half_sel   = lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    // The counter holds the number of BUS cycles already spent; abort on the
    // TIMEOUT-th one unless ack arrives in that same cycle.
    assign cnt_inc    = cnt + 1'b1;
    assign timed_out  = (TIMEOUT != 0) && (cnt_inc == TO_WIDTH'(TIMEOUT));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        be_n    = 4'b1111;
        wdata_n = mem_wdata_i;
        load_n  = bus_rdata_i;
        if (is_byte) begin
            be_n    = 4'b0001 << lane;
            wdata_n = {4{mem_wdata_i[7:0]}};
            load_n  = {{24{~mem_size_i[2] & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            be_n    = lane[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{mem_wdata_i[15:0]}};
            load_n  = {{16{~mem_size_i[2] & half_sel[15]}}, half_sel};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            abort_q <= 1'b0;
            load_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !misaligned) begin
                        req_q   <= 1'b1;
                        we_q    <= mem_we_i;
                        addr_q  <= {mem_addr_i[31:2], 2'b00};
                        wdata_q <= wdata_n;
                        be_q    <= be_n;
                        cnt     <= '0;
                        abort_q <= 1'b0;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    cnt <= cnt_inc;
                    if (bus_ack_i) begin
                        load_q <= load_n;
                        req_q  <= 1'b0;
                        state  <= DONE;
                    end else if (timed_out) begin
                        req_q   <= 1'b0;
                        abort_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_waddr_o = reg_waddr_i;
        reg_wdata_o = reg_wdata_i;
        reg_we_o    = 1'b0;
        stall_o     = 1'b0;
        err_o       = 1'b0;
        case (state)
            IDLE: begin
                if (!access)        reg_we_o = reg_we_i;
                else if (misaligned) err_o   = 1'b1;
                else                 stall_o = 1'b1;
            end
            BUS: stall_o = 1'b1;
            DONE: begin
                if (abort_q) begin
                    err_o = 1'b1;
                end else if (!we_q) begin
                    reg_we_o    = reg_we_i;
                    reg_wdata_o = load_q;
                end
            end
            default: ;
        endcase
        // Reset must silence the pipeline handshake even while an access is presented.
        if (!rst_ni) begin
            reg_we_o = 1'b0;
            stall_o  = 1'b0;
            err_o    = 1'b0;
        end
    end

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = be_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed spec scenarios plus randomized
// accesses checked against an arithmetic model of the load/store rules.
module tb_mem_lsu;
    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [2:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stall_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    mem_lsu #(.TIMEOUT(TIMEOUT), .TO_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .stall_o(stall_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic int width_of(input logic [2:0] s);
        if (s[1:0] == 2'd0) return 1;
        if (s[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] s, input logic [31:0] addr);
        return (int'(addr[1:0]) % width_of(s)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] s, input logic [31:0] addr);
        return 4'(((1 << width_of(s)) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] s, input logic [31:0] d);
        if (width_of(s) == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (width_of(s) == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int          w;
        logic [31:0] mask;
        logic [31:0] v;
        w    = width_of(s);
        mask = (w == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * w)) - 32'd1);
        v    = (rdata >> (8 * int'(addr[1:0]))) & mask;
        if (!s[2] && w < 4 && v[8 * w - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        reg_waddr_i = '0; reg_we_i = 1'b0; reg_wdata_i = '0;
        mem_re_i = 1'b0; mem_we_i = 1'b0; mem_size_i = '0;
        mem_addr_i = '0; mem_wdata_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
    endtask

    // One memory op. ack_at = BUS cycle index carrying ack, -1 = never.
    task automatic run_access(input string name, input logic re, input logic we,
                              input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_at, input logic rwe, input logic [4:0] waddr,
                              input bit gap);
        bit   mis, store, abort;
        int   len;
        logic exp_we;
        mis   = model_misaligned(size, addr);
        store = we;
        abort = !(ack_at >= 0 && ack_at < TIMEOUT);
        len   = abort ? TIMEOUT : ack_at + 1;

        @(posedge clk_i); #1;
        mem_re_i = re; mem_we_i = we; mem_size_i = size; mem_addr_i = addr;
        mem_wdata_i = wdata; reg_we_i = rwe; reg_waddr_i = waddr;
        reg_wdata_i = $urandom; bus_ack_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if ({stall_o, reg_we_o, err_o, bus_req_o} !== (mis ? 4'b0010 : 4'b1000)) begin
            n_fail++;
            $display("FAIL %s idle-flags got=%b exp=%b", name,
                     {stall_o, reg_we_o, err_o, bus_req_o}, mis ? 4'b0010 : 4'b1000);
        end
        if (mis) begin
            @(posedge clk_i); #1;
            clear_inputs();
            @(negedge clk_i);
            n_tests++;
            if ({stall_o, reg_we_o, err_o, bus_req_o} !== 4'b0000) begin
                n_fail++;
                $display("FAIL %s mis-after got=%b exp=0000", name,
                         {stall_o, reg_we_o, err_o, bus_req_o});
            end
            return;
        end

        for (int i = 0; i < len; i++) begin
            @(posedge clk_i); #1;
            bus_ack_i   = (i == ack_at);
            bus_rdata_i = (i == ack_at) ? rdata : $urandom;
            @(negedge clk_i);
            n_tests++;
            if ({stall_o, reg_we_o, err_o, bus_req_o, bus_we_o, bus_be_o, bus_addr_o} !==
                {4'b1001, store, model_be(size, addr), addr[31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL %s bus[%0d] flags/we/be/addr got=%b/%b/%b/%h exp=1001/%b/%b/%h",
                         name, i, {stall_o, reg_we_o, err_o, bus_req_o}, bus_we_o, bus_be_o,
                         bus_addr_o, store, model_be(size, addr), {addr[31:2], 2'b00});
            end
            if (store) begin
                n_tests++;
                if (bus_wdata_o !== model_wdata(size, wdata)) begin
                    n_fail++;
                    $display("FAIL %s bus_wdata got=%h exp=%h", name, bus_wdata_o,
                             model_wdata(size, wdata));
                end
            end
        end

        @(posedge clk_i); #1;
        bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        @(negedge clk_i);
        exp_we = (!store && !abort) ? rwe : 1'b0;
        n_tests++;
        if ({stall_o, reg_we_o, err_o, bus_req_o, reg_waddr_o} !== {1'b0, exp_we, abort, 1'b0, waddr}) begin
            n_fail++;
            $display("FAIL %s done stall/we/err/req/waddr got=%b/%d exp=%b/%d", name,
                     {stall_o, reg_we_o, err_o, bus_req_o}, reg_waddr_o,
                     {1'b0, exp_we, abort, 1'b0}, waddr);
        end
        if (!store && !abort) begin
            n_tests++;
            if (reg_wdata_o !== model_load(size, addr, rdata)) begin
                n_fail++;
                $display("FAIL %s load-data got=%h exp=%h", name, reg_wdata_o,
                         model_load(size, addr, rdata));
            end
        end

        if (gap) begin
            @(posedge clk_i); #1;
            clear_inputs();
            @(negedge clk_i);
            n_tests++;
            if ({stall_o, reg_we_o, err_o, bus_req_o} !== 4'b0000) begin
                n_fail++;
                $display("FAIL %s return-idle got=%b exp=0000", name,
                         {stall_o, reg_we_o, err_o, bus_req_o});
            end
        end
    endtask

    task automatic run_alu(input string name, input logic rwe, input logic [4:0] waddr,
                           input logic [31:0] wdata);
        @(posedge clk_i); #1;
        clear_inputs();
        reg_we_i = rwe; reg_waddr_i = waddr; reg_wdata_i = wdata;
        #1;
        n_tests++;
        if ({reg_we_o, reg_waddr_o, reg_wdata_o, stall_o, err_o} !== {rwe, waddr, wdata, 2'b00}) begin
            n_fail++;
            $display("FAIL %s pass we/waddr/wdata/stall/err got=%b/%d/%h/%b%b exp=%b/%d/%h/00",
                     name, reg_we_o, reg_waddr_o, reg_wdata_o, stall_o, err_o, rwe, waddr, wdata);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        #12;
        n_tests++;
        if ({bus_req_o, bus_we_o, bus_be_o, stall_o, err_o, reg_we_o, bus_addr_o, bus_wdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got req=%b we=%b be=%b stall=%b err=%b rwe=%b addr=%h wdata=%h exp=all zero",
                     bus_req_o, bus_we_o, bus_be_o, stall_o, err_o, reg_we_o, bus_addr_o, bus_wdata_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_alu();
        run_alu("alu_spec", 1'b1, 5'd5, 32'h1234);
        for (int i = 0; i < 4; i++)
            run_alu("alu_rand", 1'($urandom), 5'($urandom), $urandom);
    endtask

    task automatic test_load();
        run_access("lb_spec",  1, 0, 3'b000, 32'h103, 0, 32'h80FF_FFFF, 0, 1, 5'd7, 1);
        run_access("lbu_spec", 1, 0, 3'b100, 32'h103, 0, 32'h80FF_FFFF, 0, 1, 5'd7, 1);
        run_access("lh_hi",    1, 0, 3'b001, 32'h202, 0, 32'h9ABC_1234, 2, 1, 5'd9, 1);
        run_access("lhu_lo",   1, 0, 3'b101, 32'h200, 0, 32'h1234_F00D, 1, 1, 5'd9, 1);
        run_access("lw",       1, 0, 3'b010, 32'h300, 0, 32'hDEAD_BEEF, 0, 1, 5'd3, 1);
        run_access("ld_rwe0",  1, 0, 3'b010, 32'h304, 0, 32'h0BAD_F00D, 0, 0, 5'd3, 1);
    endtask

    task automatic test_store();
        run_access("sh_spec",  0, 1, 3'b001, 32'h22, 32'hABCD_1234, 0, 0, 1, 5'd4, 1);
        run_access("sb_lane1", 0, 1, 3'b000, 32'h41, 32'h0000_00A5, 0, 1, 1, 5'd4, 1);
        run_access("sw",       0, 1, 3'b010, 32'h48, 32'hCAFE_BABE, 0, 0, 1, 5'd4, 1);
        run_access("re_we_both", 1, 1, 3'b010, 32'h4C, 32'h1111_2222, 32'h3333_4444, 0, 1, 5'd4, 1);
    endtask

    task automatic test_misaligned();
        run_access("lw_mis_spec", 1, 0, 3'b010, 32'h102, 0, 0, 0, 1, 5'd6, 1);
        run_access("lh_mis",      1, 0, 3'b001, 32'h101, 0, 0, 0, 1, 5'd6, 1);
        run_access("sw_mis",      0, 1, 3'b010, 32'h101, 32'h5, 0, 0, 1, 5'd6, 1);
    endtask

    task automatic test_timeout();
        run_access("lw_timeout", 1, 0, 3'b010, 32'h500, 0, 0, -1, 1, 5'd8, 1);
        run_access("ack_at_limit", 1, 0, 3'b000, 32'h501, 0, 32'h0000_7F00, TIMEOUT - 1, 1, 5'd8, 1);
    endtask

    task automatic test_reset_mid_bus();
        @(posedge clk_i); #1;
        clear_inputs();
        mem_re_i = 1'b1; mem_size_i = 3'b010; mem_addr_i = 32'h600; reg_we_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        n_tests++;
        if (bus_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid pre-req got=%b exp=1", bus_req_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({bus_req_o, stall_o, reg_we_o, err_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid async got req/stall/we/err=%b exp=0000",
                     {bus_req_o, stall_o, reg_we_o, err_o});
        end
        @(posedge clk_i); #1;
        clear_inputs();
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if ({bus_req_o, stall_o, reg_we_o, err_o, bus_be_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid after got req/stall/we/err/be=%b exp=00000000",
                     {bus_req_o, stall_o, reg_we_o, err_o, bus_be_o});
        end
    endtask

    task automatic test_random();
        logic [2:0] sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            int          op;
            int          ack_at;
            logic [2:0]  sz;
            logic [31:0] addr;
            op     = $urandom_range(0, 3);
            ack_at = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
            sz     = sizes[$urandom_range(0, 4)];
            addr   = $urandom;
            if (op == 0) begin
                run_alu("rand_alu", 1'($urandom), 5'($urandom), $urandom);
            end else begin
                if (op >= 2) sz = {1'b0, sz[1:0]};
                run_access("rand_mem", op != 2, op >= 2, sz, addr, $urandom, $urandom,
                           ack_at, 1'($urandom), 5'($urandom), bit'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic test_back_to_back();
        run_access("b2b_lw", 1, 0, 3'b010, 32'h700, 0, 32'h8765_4321, 0, 1, 5'd10, 0);
        run_access("b2b_sb", 0, 1, 3'b000, 32'h702, 32'h77, 0, 0, 1, 5'd10, 0);
        run_access("b2b_lh", 1, 0, 3'b001, 32'h706, 0, 32'hFFFE_0000, 0, 1, 5'd11, 1);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
